// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared constants for immediate extension: mode encodings and
//               default datapath widths.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

    // Extension mode encodings driven by the ID-stage decoder
    localparam logic [1:0] IMM_SIGN   = 2'd0;
    localparam logic [1:0] IMM_ZERO   = 2'd1;
    localparam logic [1:0] IMM_UPPER  = 2'd2;
    localparam logic [1:0] IMM_BRANCH = 2'd3;

    // Default widths of the raw immediate and of the datapath
    localparam int IMM_IN_W = 16;
    localparam int DATA_W   = 32;

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate extender. Supports sign, zero,
//               upper-immediate and shifted branch-offset extension. Shared
//               between the single-cycle and pipelined datapaths.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = IMM_IN_W,
    parameter int OUT_W    = DATA_W,
    parameter int BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic [OUT_W-1:0] ext_o
);

    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_zero;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_branch;

    assign w_sign   = OUT_W'(signed'(data_i));
    assign w_zero   = OUT_W'(data_i);
    // Shifted-out bits fall off the top; vacated low bits are zero
    assign w_branch = w_sign << BR_SHIFT;

    // Upper placement degenerates to a pass-through when the widths match,
    // which avoids a zero-width padding field
    generate
        if (IN_W == OUT_W) begin : g_upper_full
            assign w_upper = data_i;
        end else begin : g_upper_pad
            assign w_upper = {data_i, {(OUT_W-IN_W){1'b0}}};
        end
    endgenerate

    // Select the extension result for the requested mode
    always_comb begin
        ext_o = w_sign;
        case (mode_i)
            IMM_SIGN:   ext_o = w_sign;
            IMM_ZERO:   ext_o = w_zero;
            IMM_UPPER:  ext_o = w_upper;
            IMM_BRANCH: ext_o = w_branch;
            default:    ext_o = w_sign;
        endcase
    end

endmodule : imm_ext_core
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_extend_pipe
// Description : Pipelined immediate extender with a valid/ready handshake,
//               a registered output stage and a one-entry skid buffer so that
//               ready_o is a pure register output. Synchronous flush squashes
//               both held entries.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W     = IMM_IN_W,
    parameter int OUT_W    = DATA_W,
    parameter int BR_SHIFT = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o
);

    logic             r_out_v;
    logic [OUT_W-1:0] r_out_d;
    logic             r_skid_v;
    logic [OUT_W-1:0] r_skid_d;

    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_pop;

    // Extension happens before storage: both registers hold final results
    imm_ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .data_i (data_i),
        .mode_i (mode_i),
        .ext_o  (w_ext)
    );

    assign ready_o  = ~r_skid_v;
    assign w_accept = valid_i & ready_o & ~flush_i;
    assign w_pop    = r_out_v & ready_i;

    assign valid_o  = r_out_v;
    assign data_o   = r_out_d;

    // Output register plus skid entry; skid drains into output on a pop
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
            r_out_d  <= '0;
            r_skid_d <= '0;
        end else if (flush_i) begin
            // Data registers keep their contents; only validity is squashed
            r_out_v  <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (r_skid_v) begin
            if (w_pop) begin
                r_out_d  <= r_skid_d;
                r_skid_v <= 1'b0;
            end
        end else if (w_accept && (!r_out_v || w_pop)) begin
            r_out_d <= w_ext;
            r_out_v <= 1'b1;
        end else if (w_accept) begin
            r_skid_d <= w_ext;
            r_skid_v <= 1'b1;
        end else if (w_pop) begin
            r_out_v <= 1'b0;
        end
    end

endmodule : imm_extend_pipe
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_extend_pipe
// Description : Self-checking bench for imm_extend_pipe. A FIFO-of-depth-2
//               reference model with arithmetic extension predicts every
//               output; a second instance covers an 8->16 configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        vin;
    logic        rdy_o;
    logic [15:0] din;
    logic [1:0]  mode;
    logic        vout;
    logic        rdy;
    logic [31:0] dout;

    // Narrow-configuration instance
    logic        n_rst;
    logic        n_flush;
    logic        n_vin;
    logic        n_rdy_o;
    logic [7:0]  n_din;
    logic [1:0]  n_mode;
    logic        n_vout;
    logic        n_rdy;
    logic [15:0] n_dout;

    int checks;
    int errors;

    // Reference model state: queue of extended results, head is on data_o
    logic [31:0] q[$];
    logic        zero_data;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .BR_SHIFT(2)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .valid_i (vin),
        .ready_o (rdy_o),
        .data_i  (din),
        .mode_i  (mode),
        .valid_o (vout),
        .ready_i (rdy),
        .data_o  (dout)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .BR_SHIFT(1)) dut_n (
        .clk_i   (clk),
        .rst_i   (n_rst),
        .flush_i (n_flush),
        .valid_i (n_vin),
        .ready_o (n_rdy_o),
        .data_i  (n_din),
        .mode_i  (n_mode),
        .valid_o (n_vout),
        .ready_i (n_rdy),
        .data_o  (n_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Extension computed with signed integer arithmetic and a width mask
    function automatic logic [31:0] ref_ext(input longint x, input int m,
                                            input int iw, input int ow,
                                            input int sh);
        longint s;
        longint r;
        s = (x >= (64'sd1 <<< (iw - 1))) ? x - (64'sd1 <<< iw) : x;
        case (m)
            0:       r = s;
            1:       r = x;
            2:       r = x * (64'sd1 <<< (ow - iw));
            default: r = s * (64'sd1 <<< sh);
        endcase
        r = r & ((64'sd1 <<< ow) - 1);
        return 32'(r);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the current inputs, then compare
    task automatic cyc();
        bit          m_ready;
        bit          m_valid;
        bit          acc;
        bit          pop;
        bit          stall;
        logic [31:0] held;
        m_ready = (q.size() < 2);
        m_valid = (q.size() > 0);
        acc     = vin && m_ready && !flush;
        pop     = m_valid && rdy;
        stall   = m_valid && !rdy && !rst && !flush;
        held    = m_valid ? q[0] : 32'h0;
        if (rst) begin
            q.delete();
            zero_data = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_ext(longint'(din), int'(mode), 16, 32, 2));
                zero_data = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("ready_o", 32'(rdy_o), 32'(q.size() < 2));
        chk("valid_o", 32'(vout), 32'(q.size() > 0));
        if (q.size() > 0)   chk("data_o", dout, q[0]);
        else if (zero_data) chk("data_o_zero", dout, 32'h0);
        if (stall) begin
            chk("hold_valid", 32'(vout), 32'h1);
            chk("hold_data", dout, held);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m,
                         input logic [15:0] d);
        vin  = v;
        mode = m;
        din  = d;
    endtask

    initial begin
        logic [31:0] exp_tbl[4];
        logic [1:0]  mode_tbl[4];
        logic [15:0] din_tbl[4];
        checks    = 0;
        errors    = 0;
        zero_data = 1'b1;
        rst = 1'b1; flush = 1'b0; rdy = 1'b0;
        drive(1'b0, 2'd0, 16'h0);
        n_rst = 1'b1; n_flush = 1'b0; n_vin = 1'b0; n_din = 8'h0;
        n_mode = 2'd0; n_rdy = 1'b1;

        // Reset state
        cyc();
        cyc();
        chk("reset_valid", 32'(vout), 32'h0);
        chk("reset_data", dout, 32'h0);
        chk("reset_ready", 32'(rdy_o), 32'h1);
        rst = 1'b0;
        n_rst = 1'b0;

        // Streaming all four modes at full throughput
        mode_tbl = '{2'd0, 2'd1, 2'd2, 2'd3};
        din_tbl  = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF};
        exp_tbl  = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC};
        rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mode_tbl[i], din_tbl[i]);
            cyc();
            chk("stream_valid", 32'(vout), 32'h1);
            chk("stream_data", dout, exp_tbl[i]);
        end
        drive(1'b0, 2'd0, 16'h0);
        cyc();

        // Backpressure fills both entries; third offer must wait
        rdy = 1'b0;
        drive(1'b1, 2'd0, 16'h0001);
        cyc();
        drive(1'b1, 2'd0, 16'h7FFF);
        cyc();
        chk("full_ready", 32'(rdy_o), 32'h0);
        drive(1'b1, 2'd0, 16'h0002);
        for (int i = 0; i < 5; i++) cyc();
        chk("stall_data", dout, 32'h00000001);
        rdy = 1'b1;
        cyc();
        chk("drain1", dout, 32'h00007FFF);
        chk("recover_ready", 32'(rdy_o), 32'h1);
        cyc();
        chk("drain2", dout, 32'h00000002);
        drive(1'b0, 2'd0, 16'h0);
        cyc();
        chk("drained", 32'(vout), 32'h0);

        // Flush with a full buffer and a concurrent offer
        rdy = 1'b0;
        drive(1'b1, 2'd1, 16'h1111);
        cyc();
        drive(1'b1, 2'd1, 16'h2222);
        cyc();
        flush = 1'b1;
        drive(1'b1, 2'd1, 16'h00AA);
        cyc();
        chk("flush_valid", 32'(vout), 32'h0);
        chk("flush_ready", 32'(rdy_o), 32'h1);
        flush = 1'b0;
        drive(1'b0, 2'd0, 16'h0);
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) cyc();

        // Reset mid-stream with two entries held
        rdy = 1'b0;
        drive(1'b1, 2'd3, 16'h0100);
        cyc();
        drive(1'b1, 2'd2, 16'h0200);
        cyc();
        rst = 1'b1;
        drive(1'b0, 2'd0, 16'h0);
        cyc();
        chk("midrst_valid", 32'(vout), 32'h0);
        chk("midrst_data", dout, 32'h0);
        chk("midrst_ready", 32'(rdy_o), 32'h1);
        rst = 1'b0;
        rdy = 1'b1;
        drive(1'b1, 2'd0, 16'hFFFE);
        cyc();
        chk("post_rst", dout, 32'hFFFFFFFE);
        drive(1'b0, 2'd0, 16'h0);
        cyc();

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                  16'($urandom));
            rdy   = 1'($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 79) == 0);
            cyc();
        end
        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 2'd0, 16'h0);
        rdy = 1'b1;
        cyc();
        cyc();

        // Narrow configuration: 8 -> 16, branch shift 1
        mode_tbl = '{2'd0, 2'd2, 2'd3, 2'd1};
        din_tbl  = '{16'h0080, 16'h005A, 16'h00C0, 16'h00F0};
        exp_tbl  = '{32'hFF80, 32'h5A00, 32'hFF80, 32'h00F0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vin  = 1'b1;
            n_mode = mode_tbl[i];
            n_din  = din_tbl[i][7:0];
            @(posedge clk);
            #1;
            n_vin = 1'b0;
            chk("narrow_valid", 32'(n_vout), 32'h1);
            chk("narrow_data", 32'(n_dout), exp_tbl[i]);
            chk("narrow_model", 32'(n_dout),
                ref_ext(longint'(din_tbl[i][7:0]), int'(mode_tbl[i]), 8, 16, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_imm_extend_pipe
`default_nettype wire

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender for the pipelined CPU datapath, sitting between ID-stage immediate decode and the ID/EX operand path.
- Generalises plain 16->32 sign extension to configurable widths and four modes: sign, zero, upper-immediate (LUI) and shifted branch offset.
- Adds a valid/ready handshake with a one-cycle registered output plus a one-entry skid buffer, so ready_o carries no combinational path from ready_i.
- Provides a synchronous flush for branch and hazard squash.

Parameters:
- IN_W, 16, immediate input width; must satisfy 1 <= IN_W <= OUT_W.
- OUT_W, 32, extended output width.
- BR_SHIFT, 2, left-shift amount applied in branch mode; must satisfy 0 <= BR_SHIFT < OUT_W.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- flush_i  in  1  synchronous squash of all held entries.
- valid_i  in  1  input immediate valid.
- ready_o  out  1  block can accept an input this cycle.
- data_i  in  IN_W  raw immediate.
- mode_i  in  2  extension mode, sampled with data_i.
- valid_o  out  1  data_o holds a valid result.
- ready_i  in  1  downstream accepts data_o this cycle.
- data_o  out  OUT_W  extended result.

Behaviour:
- Modes (x = data_i):
  - 0 SIGN: bits [IN_W-1:0] = x; upper bits = x[IN_W-1].
  - 1 ZERO: bits [IN_W-1:0] = x; upper bits = 0.
  - 2 UPPER: bits [OUT_W-1:OUT_W-IN_W] = x; lower bits = 0. If IN_W == OUT_W, result = x.
  - 3 BRANCH: SIGN result shifted left by BR_SHIFT and truncated to OUT_W. Shifted-out bits are discarded; vacated bits are 0.
- Extension is applied at accept time. Registers hold extended values, not raw inputs.
- State:
  - out_v/out_d: output register; drives valid_o/data_o.
  - skid_v/skid_d: skid register.
- ready_o = ~skid_v. This is a pure register output.
- Define accept = valid_i & ready_o & ~flush_i, and pop = out_v & ready_i.
- Per rising edge, in priority order:
  1. rst_i: out_v = 0, skid_v = 0, out_d = 0, skid_d = 0. Reset wins over everything; an in-flight entry is discarded.
  2. flush_i: out_v = 0 and skid_v = 0. Data registers are unchanged. A concurrent input is dropped, and a concurrent pop is ignored by this block (the downstream must also squash).
  3. If skid_v:
     - pop: out_d = skid_d, skid_v = 0.
     - No pop: hold.
     - No accept is possible in this state.
  4. Else if accept and (~out_v or pop): out_d = ext(data_i, mode_i), out_v = 1.
  5. Else if accept (out_v and ~pop): skid_d = ext(data_i, mode_i), skid_v = 1. out is held.
  6. Else if pop: out_v = 0.
- Reset values: valid_o = 0, data_o = 0, ready_o = 1.
- Latency is 1 cycle: an input accepted at edge N appears on data_o after edge N.
- Throughput is 1 per cycle while ready_i = 1.
- Ordering is strict FIFO. Capacity is 2 entries.
- Full condition: skid_v = 1, so ready_o = 0. Recovery: ready_o returns to 1 one cycle after the first pop.
- Stability: data_o and valid_o must not change while valid_o = 1 and ready_i = 0, except on rst_i or flush_i.
- Unknown or X on mode_i is never produced by the decoder; behaviour in that case is not specified.

Decomposition:
- Shared package imm_ext_pkg holds:
  - Mode constants IMM_SIGN = 2'd0, IMM_ZERO = 2'd1, IMM_UPPER = 2'd2, IMM_BRANCH = 2'd3.
  - Default widths IMM_IN_W = 16, DATA_W = 32.
- One combinational sub-module, imm_ext_core (data_i, mode_i -> ext_o, parametrised IN_W/OUT_W/BR_SHIFT). It is also reusable by the single-cycle datapath.
- The handshake and skid logic live in imm_extend_pipe.

Test Plan:
1. ready_i = 1; stream SIGN 0x8000, ZERO 0x8000, UPPER 0x1234, BRANCH 0xFFFF -> data_o is 0xFFFF8000, 0x00008000, 0x12340000, 0xFFFFFFFC on consecutive cycles, 1 cycle after each accept, with valid_o held high.
2. Backpressure: ready_i = 0; offer SIGN 0x0001 then 0x7FFF, and keep valid_i high with 0x0002 -> ready_o falls after the second accept, and the third is not taken. Raise ready_i -> outputs are 0x00000001, 0x00007FFF, 0x00000002 in order, with no loss or duplication.
3. Hold stability: with valid_o = 1 and ready_i = 0 for 5 cycles, data_o is constant. This is checked with an assertion throughout all tests.
4. Flush with a full buffer, concurrent with valid_i = 1 (0x00AA) -> next cycle valid_o = 0 and ready_o = 1, and 0x00AA never appears.
5. rst_i asserted mid-stream with 2 entries held -> next cycle valid_o = 0, data_o = 0, ready_o = 1. A subsequent SIGN 0xFFFE yields 0xFFFFFFFE.
6. Parameter variant IN_W = 8, OUT_W = 16, BR_SHIFT = 1: SIGN 0x80 -> 0xFF80; UPPER 0x5A -> 0x5A00; BRANCH 0xC0 -> 0xFF80.
